mem_sel_seq: RTL and testbench

Parametrised memory module/sector select sequencer; next generation of the fixed eight-way module/sector select logic. Holds separate instruction and data module/sector registers and a duplex flag for each. Loads them from a bit-serial HOP word and runs a setup/read/acknowledge sequence for each memory access. Sits between the HOP register path and the memory module array, driving active-low module selects, the sector address and the read enable.

---
 rtl/mem_sel_pkg.sv | 46 ++++
 rtl/mem_mod_decode.sv | 22 ++
 rtl/mem_sel_seq.sv | 147 ++++++++++++++
 tb/tb_mem_sel_seq.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sel_pkg.sv
// Shared types and HOP word layout helpers for the module/sector select sequencer.
// The HOP word holds an instruction half (ISECT, IMOD, DUPI) below a data half (DSECT, DMOD, DUPD).
package mem_sel_pkg;

    localparam int MOD_W_MAX  = 8;
    localparam int SECT_W_MAX = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        READ  = 2'd2,
        ACK   = 2'd3
    } state_t;

    // Fields are sized for the largest supported configuration; narrower ones are zero-extended.
    typedef struct packed {
        logic                  dup;
        logic [MOD_W_MAX-1:0]  mod;
        logic [SECT_W_MAX-1:0] sect;
    } sel_reg_t;

    function automatic int mod_w(input int n_mod);
        return $clog2(n_mod);
    endfunction

    function automatic int half_w(input int n_mod, input int sect_w);
        return mod_w(n_mod) + sect_w + 1;
    endfunction

    function automatic int hop_w(input int n_mod, input int sect_w);
        return 2 * half_w(n_mod, sect_w);
    endfunction

    function automatic int sect_off(input int n_mod, input int sect_w, input bit data);
        return data ? half_w(n_mod, sect_w) : 0;
    endfunction

    function automatic int mod_off(input int n_mod, input int sect_w, input bit data);
        return sect_off(n_mod, sect_w, data) + sect_w;
    endfunction

    function automatic int dup_off(input int n_mod, input int sect_w, input bit data);
        return mod_off(n_mod, sect_w, data) + mod_w(n_mod);
    endfunction

endpackage

// File: rtl/mem_mod_decode.sv
// Combinational module decoder: produces active-low selects for one module,
// or for the even/odd module pair containing it when duplex is requested.
module mem_mod_decode #(
    parameter int N_MOD = 8
) (
    input  logic [$clog2(N_MOD)-1:0] mod,
    input  logic                     dup,
    output logic [N_MOD-1:0]         sel_n
);

    localparam int MOD_W = $clog2(N_MOD);

    // Forcing the LSB high on both sides makes a module match its duplex partner.
    always_comb begin
        sel_n = '1;
        for (int i = 0; i < N_MOD; i++) begin
            sel_n[i] = dup ? ((MOD_W'(i) | MOD_W'(1)) != (mod | MOD_W'(1)))
                           : (MOD_W'(i) != mod);
        end
    end

endmodule

// File: rtl/mem_sel_seq.sv
// Memory module/sector select sequencer: loads instruction/data select registers from a
// bit-serial HOP word and runs a setup/read/acknowledge sequence for each access.
module mem_sel_seq
    import mem_sel_pkg::*;
#(
    parameter int N_MOD     = 8,
    parameter int SECT_W    = 4,
    parameter int SETUP_CYC = 2,
    parameter int READ_CYC  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hop_bit,
    input  logic              hop_shift,
    input  logic              hop_load,
    input  logic              acc_req,
    input  logic              acc_data,
    output logic [N_MOD-1:0]  msel_n,
    output logic [SECT_W-1:0] sect,
    output logic              rden,
    output logic              acc_ack,
    output logic              busy
);

    localparam int MOD_W   = mod_w(N_MOD);
    localparam int HOP_W   = hop_w(N_MOD, SECT_W);
    localparam int MAX_CYC = (SETUP_CYC > READ_CYC) ? SETUP_CYC : READ_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam int I_SECT = sect_off(N_MOD, SECT_W, 1'b0);
    localparam int I_MOD  = mod_off(N_MOD, SECT_W, 1'b0);
    localparam int I_DUP  = dup_off(N_MOD, SECT_W, 1'b0);
    localparam int D_SECT = sect_off(N_MOD, SECT_W, 1'b1);
    localparam int D_MOD  = mod_off(N_MOD, SECT_W, 1'b1);
    localparam int D_DUP  = dup_off(N_MOD, SECT_W, 1'b1);

    logic [HOP_W-1:0] sr;
    sel_reg_t         ireg;
    sel_reg_t         dreg;
    sel_reg_t         hop_i;
    sel_reg_t         hop_d;
    sel_reg_t         next_sel;
    logic             pending;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [N_MOD-1:0] dec_n;

    // A load in the same cycle as a request bypasses the registers so the access sees the new word.
    always_comb begin
        hop_i = '{dup:  sr[I_DUP],
                  mod:  MOD_W_MAX'(sr[I_MOD +: MOD_W]),
                  sect: SECT_W_MAX'(sr[I_SECT +: SECT_W])};
        hop_d = '{dup:  sr[D_DUP],
                  mod:  MOD_W_MAX'(sr[D_MOD +: MOD_W]),
                  sect: SECT_W_MAX'(sr[D_SECT +: SECT_W])};
        if (acc_data) begin
            next_sel = hop_load ? hop_d : dreg;
        end else begin
            next_sel = hop_load ? hop_i : ireg;
        end
    end

    mem_mod_decode #(
        .N_MOD (N_MOD)
    ) u_decode (
        .mod   (MOD_W'(next_sel.mod)),
        .dup   (next_sel.dup),
        .sel_n (dec_n)
    );

    // Selects and sector are captured once on entry to SETUP and held until the access ends,
    // so the select registers may change underneath without disturbing the access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr      <= '0;
            ireg    <= '0;
            dreg    <= '0;
            pending <= 1'b0;
            state   <= IDLE;
            cnt     <= '0;
            msel_n  <= '1;
            sect    <= '0;
            rden    <= 1'b0;
            acc_ack <= 1'b0;
            busy    <= 1'b0;
        end else begin
            if (hop_shift) begin
                sr <= {hop_bit, sr[HOP_W-1:1]};
            end
            case (state)
                IDLE: begin
                    if (hop_load) begin
                        ireg <= hop_i;
                        dreg <= hop_d;
                    end
                    if (acc_req) begin
                        state  <= SETUP;
                        cnt    <= CNT_W'(SETUP_CYC - 1);
                        msel_n <= dec_n;
                        sect   <= SECT_W'(next_sel.sect);
                        busy   <= 1'b1;
                    end
                end
                SETUP: begin
                    if (hop_load) begin
                        pending <= 1'b1;
                    end
                    if (cnt == '0) begin
                        state <= READ;
                        cnt   <= CNT_W'(READ_CYC - 1);
                        rden  <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                READ: begin
                    if (hop_load) begin
                        pending <= 1'b1;
                    end
                    if (cnt == '0) begin
                        state   <= ACK;
                        rden    <= 1'b0;
                        acc_ack <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ACK: begin
                    // A load arriving in the ACK cycle itself is honoured on this same edge.
                    if (pending || hop_load) begin
                        ireg <= hop_i;
                        dreg <= hop_d;
                    end
                    pending <= 1'b0;
                    state   <= IDLE;
                    acc_ack <= 1'b0;
                    busy    <= 1'b0;
                    msel_n  <= '1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_sel_seq.sv
// Bench for mem_sel_seq: three configurations driven by directed and random HOP/access
// traffic, with expected selects queued at request time and checked by a separate monitor.
module tb_mem_sel_seq;

    typedef struct {
        int msel;
        int sect;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic hop_bit_a[3];
    logic hop_shift_a[3];
    logic hop_load_a[3];
    logic acc_req_a[3];
    logic acc_data_a[3];
    logic rden_a[3];
    logic ack_a[3];
    logic busy_a[3];
    logic [7:0]  m0;
    logic [15:0] m1;
    logic [1:0]  m2;
    logic [3:0]  s0;
    logic [5:0]  s1;
    logic [3:0]  s2;
    logic [15:0] msel_a[3];
    logic [7:0]  sect_a[3];

    assign msel_a[0] = 16'(m0);
    assign msel_a[1] = m1;
    assign msel_a[2] = 16'(m2);
    assign sect_a[0] = 8'(s0);
    assign sect_a[1] = 8'(s1);
    assign sect_a[2] = 8'(s2);

    mem_sel_seq #(.N_MOD(8), .SECT_W(4), .SETUP_CYC(2), .READ_CYC(3)) dut0 (
        .clk(clk), .reset(reset), .hop_bit(hop_bit_a[0]), .hop_shift(hop_shift_a[0]),
        .hop_load(hop_load_a[0]), .acc_req(acc_req_a[0]), .acc_data(acc_data_a[0]),
        .msel_n(m0), .sect(s0), .rden(rden_a[0]), .acc_ack(ack_a[0]), .busy(busy_a[0]));

    mem_sel_seq #(.N_MOD(16), .SECT_W(6), .SETUP_CYC(1), .READ_CYC(1)) dut1 (
        .clk(clk), .reset(reset), .hop_bit(hop_bit_a[1]), .hop_shift(hop_shift_a[1]),
        .hop_load(hop_load_a[1]), .acc_req(acc_req_a[1]), .acc_data(acc_data_a[1]),
        .msel_n(m1), .sect(s1), .rden(rden_a[1]), .acc_ack(ack_a[1]), .busy(busy_a[1]));

    mem_sel_seq #(.N_MOD(2), .SECT_W(4), .SETUP_CYC(1), .READ_CYC(1)) dut2 (
        .clk(clk), .reset(reset), .hop_bit(hop_bit_a[2]), .hop_shift(hop_shift_a[2]),
        .hop_load(hop_load_a[2]), .acc_req(acc_req_a[2]), .acc_data(acc_data_a[2]),
        .msel_n(m2), .sect(s2), .rden(rden_a[2]), .acc_ack(ack_a[2]), .busy(busy_a[2]));

    function automatic int nmod_of(input int k);
        case (k)
            0:       return 8;
            1:       return 16;
            default: return 2;
        endcase
    endfunction

    function automatic int sectw_of(input int k);
        return (k == 1) ? 6 : 4;
    endfunction

    function automatic int setup_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic int read_of(input int k);
        return (k == 0) ? 3 : 1;
    endfunction

    function automatic int modw_of(input int k);
        return $clog2(nmod_of(k));
    endfunction

    function automatic int hopw_of(input int k);
        return 2 * (modw_of(k) + sectw_of(k)) + 2;
    endfunction

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: shift register contents, select registers and pending flag per DUT.
    int   msr[3];
    int   imod[3], isect[3], idup[3], dmod[3], dsect[3], ddup[3];
    bit   pend[3];
    exp_t expq[3][$];

    function automatic int field(input int word, input int off, input int w);
        return (word >> off) & ((1 << w) - 1);
    endfunction

    function automatic int exp_msel(input int k, input int m, input int dup);
        int all;
        int base;
        all = (1 << nmod_of(k)) - 1;
        if (dup != 0) begin
            base = (m / 2) * 2;
            return all & ~(1 << base) & ~(1 << (base + 1));
        end
        return all & ~(1 << m);
    endfunction

    function automatic int build_hop(input int k, input int im, input int is, input int id,
                                     input int dm, input int ds, input int dd);
        int sw, mw, half;
        sw   = sectw_of(k);
        mw   = modw_of(k);
        half = sw + mw + 1;
        return is + (im << sw) + (id << (sw + mw)) + ((ds + (dm << sw) + (dd << (sw + mw))) << half);
    endfunction

    task automatic model_load(input int k);
        int sw, mw, half;
        sw   = sectw_of(k);
        mw   = modw_of(k);
        half = sw + mw + 1;
        isect[k] = field(msr[k], 0, sw);
        imod[k]  = field(msr[k], sw, mw);
        idup[k]  = field(msr[k], sw + mw, 1);
        dsect[k] = field(msr[k], half, sw);
        dmod[k]  = field(msr[k], half + sw, mw);
        ddup[k]  = field(msr[k], half + sw + mw, 1);
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            msr[k] = 0; imod[k] = 0; isect[k] = 0; idup[k] = 0;
            dmod[k] = 0; dsect[k] = 0; ddup[k] = 0; pend[k] = 1'b0;
            expq[k].delete();
        end
    endtask

    function automatic exp_t expect_for(input int k, input logic data);
        exp_t e;
        e.msel = data ? exp_msel(k, dmod[k], ddup[k]) : exp_msel(k, imod[k], idup[k]);
        e.sect = data ? dsect[k] : isect[k];
        return e;
    endfunction

    // Drives one cycle of inputs (called just after a falling edge) and advances the model
    // the way the spec orders same-cycle events: load, then request, then shift.
    task automatic applyStimulus(input int k, input logic shift, input logic b, input logic load,
                                 input logic req, input logic data, input bit mid);
        hop_shift_a[k] = shift;
        hop_bit_a[k]   = b;
        hop_load_a[k]  = load;
        acc_req_a[k]   = req;
        acc_data_a[k]  = data;
        if (load) begin
            if (mid) pend[k] = 1'b1;
            else     model_load(k);
        end
        if (req && !mid) expq[k].push_back(expect_for(k, data));
        if (shift) msr[k] = (msr[k] >> 1) | (int'(b) << (hopw_of(k) - 1));
        @(negedge clk);
        hop_shift_a[k] = 1'b0;
        hop_bit_a[k]   = 1'b0;
        hop_load_a[k]  = 1'b0;
        acc_req_a[k]   = 1'b0;
        acc_data_a[k]  = 1'b0;
    endtask

    task automatic shift_hop(input int k, input int word);
        for (int i = 0; i < hopw_of(k); i++) begin
            applyStimulus(k, 1'b1, 1'((word >> i) & 1), 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while (busy_a[k] !== 1'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait idle dut%0d: busy still 0x%0h, want 0x0", k, busy_a[k]);
        end
        if (pend[k]) begin
            model_load(k);
            pend[k] = 1'b0;
        end
    endtask

    // Monitor: compares each access against the oldest queued expectation.
    bit   mon_en = 1'b0;
    int   start_c[3], rfirst[3], rcnt[3], last_sect[3];
    bit   prevb[3];
    exp_t cur[3];

    task automatic monitor_step(input int k);
        int mask, smask;
        mask  = (1 << nmod_of(k)) - 1;
        smask = (1 << sectw_of(k)) - 1;
        if (busy_a[k] === 1'b1 && !prevb[k]) begin
            checkOutput($sformatf("dut%0d expected access queued", k), 32'(expq[k].size() > 0), 1);
            if (expq[k].size() > 0) cur[k] = expq[k][0];
            start_c[k] = cyc;
            rcnt[k]    = 0;
            rfirst[k]  = -1;
        end
        if (busy_a[k] === 1'b1) begin
            checkOutput($sformatf("dut%0d msel_n", k), 32'(msel_a[k]) & mask, cur[k].msel);
            checkOutput($sformatf("dut%0d sect", k), 32'(sect_a[k]) & smask, cur[k].sect);
            if (rden_a[k] === 1'b1) begin
                rcnt[k]++;
                if (rfirst[k] < 0) rfirst[k] = cyc - start_c[k];
            end
            if (ack_a[k] === 1'b1) begin
                checkOutput($sformatf("dut%0d ack latency", k), cyc - start_c[k], setup_of(k) + read_of(k));
                checkOutput($sformatf("dut%0d rden start", k), rfirst[k], setup_of(k));
                checkOutput($sformatf("dut%0d rden length", k), rcnt[k], read_of(k));
                if (expq[k].size() > 0) void'(expq[k].pop_front());
                last_sect[k] = cur[k].sect;
            end
        end else begin
            checkOutput($sformatf("dut%0d idle msel_n", k), 32'(msel_a[k]) & mask, mask);
            checkOutput($sformatf("dut%0d idle sect hold", k), 32'(sect_a[k]) & smask, last_sect[k]);
            checkOutput($sformatf("dut%0d idle rden", k), rden_a[k], 0);
            checkOutput($sformatf("dut%0d idle ack", k), ack_a[k], 0);
        end
        prevb[k] = (busy_a[k] === 1'b1);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 3; k++) monitor_step(k);
        end
    end

    task automatic random_ops(input int k, input int iters);
        int    nb;
        int    op;
        logic  data;
        for (int it = 0; it < iters; it++) begin
            nb = $urandom_range(0, hopw_of(k));
            for (int i = 0; i < nb; i++) begin
                applyStimulus(k, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0);
            end
            op   = $urandom_range(0, 3);
            data = 1'($urandom_range(0, 1));
            case (op)
                0: applyStimulus(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, 1'b0);
                1: applyStimulus(k, 1'b0, 1'b0, 1'b0, 1'b1, data, 1'b0);
                2: applyStimulus(k, 1'b0, 1'b0, 1'b1, 1'b1, data, 1'b0);
                default: begin
                    applyStimulus(k, 1'b0, 1'b0, 1'b0, 1'b1, data, 1'b0);
                    applyStimulus(k, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
                    if ($urandom_range(0, 1) == 1) applyStimulus(k, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
                end
            endcase
            wait_idle(k);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   n;
        logic saw_ack;

        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            hop_bit_a[k] = 1'b0; hop_shift_a[k] = 1'b0; hop_load_a[k] = 1'b0;
            acc_req_a[k] = 1'b0; acc_data_a[k] = 1'b0;
            last_sect[k] = 0; prevb[k] = 1'b0;
        end
        model_clear();
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("dut%0d reset msel_n", k), 32'(msel_a[k]), (1 << nmod_of(k)) - 1);
            checkOutput($sformatf("dut%0d reset sect", k), 32'(sect_a[k]), 0);
            checkOutput($sformatf("dut%0d reset rden", k), rden_a[k], 0);
            checkOutput($sformatf("dut%0d reset ack", k), ack_a[k], 0);
            checkOutput($sformatf("dut%0d reset busy", k), busy_a[k], 0);
        end
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        $display("[TB] simplex instruction access");
        shift_hop(0, build_hop(0, 5, 'hA, 0, 5, 3, 1));
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("plan simplex msel_n", 32'(m0), 32'hDF);
        checkOutput("plan simplex sect", 32'(s0), 32'hA);
        wait_idle(0);

        $display("[TB] duplex data access");
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("plan duplex msel_n", 32'(m0), 32'hCF);
        wait_idle(0);

        $display("[TB] deferred load");
        shift_hop(0, build_hop(0, 2, 6, 0, 5, 3, 1));
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("deferred keeps old module", 32'(m0), 32'hDF);
        wait_idle(0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("deferred new module", 32'(m0), 32'hFB);
        wait_idle(0);

        $display("[TB] same-cycle events");
        shift_hop(0, build_hop(0, 7, 1, 0, 0, 0, 0));
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("request with load msel_n", 32'(m0), 32'h7F);
        wait_idle(0);
        shift_hop(0, build_hop(0, 1, 2, 0, 0, 0, 0));
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("shift with load msel_n", 32'(m0), 32'hFD);
        wait_idle(0);

        $display("[TB] decode sweep");
        for (int k = 1; k < 3; k++) begin
            for (int m = 0; m < nmod_of(k); m++) begin
                shift_hop(k, build_hop(k, m, $urandom_range(0, (1 << sectw_of(k)) - 1), 0,
                                       nmod_of(k) - 1 - m, 1, 1));
                applyStimulus(k, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                applyStimulus(k, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                wait_idle(k);
                applyStimulus(k, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
                wait_idle(k);
            end
        end

        $display("[TB] random traffic");
        for (int k = 0; k < 3; k++) random_ops(k, 30);

        $display("[TB] back-to-back requests");
        expq[1].push_back(expect_for(1, 1'b0));
        expq[1].push_back(expect_for(1, 1'b0));
        acc_req_a[1] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack_a[1] !== 1'b1 && n < 40);
        checkOutput("b2b first ack seen", ack_a[1], 1);
        @(negedge clk);
        checkOutput("b2b idle gap", busy_a[1], 0);
        @(negedge clk);
        checkOutput("b2b restart", busy_a[1], 1);
        acc_req_a[1] = 1'b0;
        wait_idle(1);

        $display("[TB] reset during read");
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (rden_a[0] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reached read phase", rden_a[0], 1);
        mon_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset msel_n", 32'(m0), 32'hFF);
        checkOutput("async reset rden", rden_a[0], 0);
        checkOutput("async reset busy", busy_a[0], 0);
        checkOutput("async reset ack", ack_a[0], 0);
        checkOutput("async reset sect", 32'(s0), 0);
        model_clear();
        for (int k = 0; k < 3; k++) begin
            last_sect[k] = 0;
            prevb[k]     = 1'b0;
        end
        @(negedge clk);
        reset = 1'b0;
        saw_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            saw_ack = saw_ack | ack_a[0];
        end
        checkOutput("no ack after reset", saw_ack, 0);
        mon_en = 1'b1;
        shift_hop(0, build_hop(0, 6, 9, 0, 3, 4, 0));
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("post-reset module 0", 32'(m0), 32'hFE);
        wait_idle(0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("pending load discarded", 32'(m0), 32'hFE);
        wait_idle(0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
